red_accum: RTL and testbench

RED_ACCUM -- requirements
Module: red_accum

---
 rtl/red_pkg.sv | 15 +
 rtl/sat_add16.sv | 31 +++
 rtl/red_accum.sv | 87 ++++++++
 tb/tb_red_accum.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/red_pkg.sv
// Shared definitions for the reduction accumulator: FSM encoding,
// saturation bounds and the default burst-length field width.
package red_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [15:0] SAT_MAX   = 16'h7FFF;
    localparam logic [15:0] SAT_MIN   = 16'h8000;
    localparam int          LEN_W_DEF = 4;

endpackage

// File: rtl/sat_add16.sv
// Combinational signed saturating adder: clamps to the most positive or
// most negative value on overflow and reports the overflow.
module sat_add16
    import red_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] Sum,
    output logic         Ovfl
);

    localparam logic [W-1:0] MAX_V = (W == 16) ? W'(SAT_MAX) : {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_V = (W == 16) ? W'(SAT_MIN) : {1'b1, {(W-1){1'b0}}};

    // Overflow only when both operands share a sign the raw sum does not.
    function automatic logic [W:0] sat_add(input logic signed [W-1:0] a,
                                           input logic signed [W-1:0] b);
        logic signed [W-1:0] raw;
        logic                ov;
        raw = a + b;
        ov  = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
        if (ov)
            return {1'b1, (a[W-1] ? MIN_V : MAX_V)};
        return {1'b0, raw};
    endfunction

    assign {Ovfl, Sum} = sat_add(A, B);

endmodule

// File: rtl/red_accum.sv
// Burst accumulator for reduction-unit sums: counts len beats, saturates
// the running total and holds the result until downstream accepts it.
module red_accum
    import red_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     red_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     acc_out,
    output logic             ovfl,
    output logic             zero,
    output logic             neg,
    output logic             busy
);

    state_t              state;
    logic [LEN_W-1:0]    cnt;
    logic signed [W-1:0] acc;
    logic [W-1:0]        sum_nxt;
    logic                add_ovfl;
    logic                beat;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign beat      = in_valid & in_ready;
    assign acc_out   = acc;

    sat_add16 #(.W(W)) u_sat (
        .A    (acc),
        .B    (red_sum),
        .Sum  (sum_nxt),
        .Ovfl (add_ovfl)
    );

    // flush shares the reset path so a beat or handshake in the same cycle is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            ovfl  <= 1'b0;
            zero  <= 1'b0;
            neg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        ovfl  <= 1'b0;
                        zero  <= 1'b1;
                        neg   <= 1'b0;
                        cnt   <= len;
                        state <= (len == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc   <= sum_nxt;
                        zero  <= (sum_nxt == '0);
                        neg   <= sum_nxt[W-1];
                        ovfl  <= ovfl | add_ovfl;
                        cnt   <= cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1))
                            state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_red_accum.sv
// Randomized bench for red_accum against a transaction-level model that
// sums each burst with per-beat signed clamping.
module tb_red_accum;

    localparam int LEN_W = 4;
    localparam int W     = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     red_sum;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     acc_out;
    logic             ovfl;
    logic             zero;
    logic             neg;
    logic             busy;

    int checks = 0;
    int errors = 0;
    logic [15:0] bq[$];

    red_accum #(.LEN_W(LEN_W), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .red_sum   (red_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .ovfl      (ovfl),
        .zero      (zero),
        .neg       (neg),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_clear(input string tag);
        chk({tag, "_acc"},  32'(acc_out),   32'h0);
        chk({tag, "_ovfl"}, 32'(ovfl),      32'h0);
        chk({tag, "_zero"}, 32'(zero),      32'h0);
        chk({tag, "_neg"},  32'(neg),       32'h0);
        chk({tag, "_ovld"}, 32'(out_valid), 32'h0);
        chk({tag, "_irdy"}, 32'(in_ready),  32'h0);
        chk({tag, "_busy"}, 32'(busy),      32'h0);
    endtask

    // Runs one burst of the beats in bq; n is the len presented with start.
    task automatic run_burst(input string tag, input int n, input int gap_max, input int hold);
        int          acc;
        bit          ov;
        int          g;
        logic [15:0] exp;
        acc = 0;
        ov  = 1'b0;
        foreach (bq[i]) begin
            acc += int'($signed(bq[i]));
            if (acc > 32767) begin
                acc = 32767;
                ov  = 1'b1;
            end else if (acc < -32768) begin
                acc = -32768;
                ov  = 1'b1;
            end
        end
        exp = acc[15:0];

        start = 1'b1;
        len   = n[LEN_W-1:0];
        tick();
        start = 1'b0;
        if (n != 0) begin
            chk({tag, "_rdy"}, 32'(in_ready), 32'h1);
            for (int i = 0; i < n; i++) begin
                g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
                for (int k = 0; k < g; k++) begin
                    in_valid = 1'b0;
                    red_sum  = 16'($urandom);
                    start    = 1'($urandom_range(1, 0));
                    len      = LEN_W'($urandom);
                    tick();
                    start = 1'b0;
                    chk({tag, "_gap_rdy"},  32'(in_ready),  32'h1);
                    chk({tag, "_gap_ovld"}, 32'(out_valid), 32'h0);
                end
                in_valid = 1'b1;
                red_sum  = bq[i];
                tick();
                in_valid = 1'b0;
            end
        end
        chk({tag, "_ovld"}, 32'(out_valid), 32'h1);
        chk({tag, "_acc"},  32'(acc_out),   32'(exp));
        chk({tag, "_zero"}, 32'(zero),      32'(exp == 16'h0));
        chk({tag, "_neg"},  32'(neg),       32'(exp[15]));
        chk({tag, "_ovfl"}, 32'(ovfl),      32'(ov));
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            start     = 1'($urandom_range(1, 0));
            len       = LEN_W'($urandom);
            tick();
            start = 1'b0;
            chk({tag, "_hold_ovld"}, 32'(out_valid), 32'h1);
            chk({tag, "_hold_acc"},  32'(acc_out),   32'(exp));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_post_ovld"}, 32'(out_valid), 32'h0);
        chk({tag, "_post_busy"}, 32'(busy),      32'h0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        red_sum   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check_idle_clear("reset");
        rst_n = 1'b1;
        tick();

        bq = '{16'h0005, 16'hFFFE, 16'h0010};
        run_burst("basic3", 3, 0, 0);

        bq = '{16'h0038, 16'h0038, 16'h0038, 16'h0038};
        run_burst("gaps4", 4, 3, 1);

        bq = {};
        for (int i = 0; i < 15; i++) bq.push_back(16'h7FF0);
        run_burst("possat", 15, 0, 0);
        bq = '{16'h0001};
        run_burst("after_sat", 1, 0, 0);

        bq = '{16'h8000, 16'h8000, 16'h0001};
        run_burst("negsat", 3, 1, 0);

        bq = {};
        run_burst("len0", 0, 0, 5);

        // Abort after two beats with a third beat presented alongside flush.
        start = 1'b1;
        len   = 4'd5;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        red_sum  = 16'h0100;
        tick();
        tick();
        flush   = 1'b1;
        red_sum = 16'h0050;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_idle_clear("flush");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("flush_quiet", 32'(out_valid), 32'h0);
        end
        start = 1'b1;
        flush = 1'b1;
        len   = 4'd3;
        tick();
        start = 1'b0;
        flush = 1'b0;
        chk("flush_vs_start", 32'(busy), 32'h0);

        for (int b = 0; b < 25; b++) begin
            int n;
            n  = int'($urandom_range(15, 1));
            bq = {};
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(2, 0))
                    0:       bq.push_back(16'($urandom_range(255, 0)));
                    1:       bq.push_back(16'($urandom));
                    default: bq.push_back(($urandom_range(1, 0) != 0) ? 16'h7000 : 16'h9000);
                endcase
            end
            run_burst("rand", n, 2, int'($urandom_range(2, 0)));
        end

        // Reset lands in DONE while downstream is ready: no handshake completes.
        bq = '{16'h1234};
        start = 1'b1;
        len   = 4'd1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        red_sum  = 16'h1234;
        tick();
        in_valid = 1'b0;
        chk("rst_done_ovld", 32'(out_valid), 32'h1);
        chk("rst_done_acc",  32'(acc_out),   32'h1234);
        rst_n     = 1'b0;
        out_ready = 1'b1;
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b0;
        check_idle_clear("rst_done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
